sam_cmd_arbiter: RTL and testbench

Shares the single SAM command stream (sam_wrapper in_* port) between two requesters using packet-atomic round-robin arbitration. It records the issuing requester of every LOAD in an ordered tag FIFO, and routes each sam_wrapper out_* response packet back to that requester. It sits directly in front of sam_wrapper, and host/engine masters attach to ports s0/s1.

---
 rtl/sam_cmd_arbiter.sv | 160 ++++++++++++++++
 tb/tb_sam_cmd_arbiter.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/sam_cmd_arbiter.sv
// Two-requester, packet-atomic round-robin front end for the SAM command stream.
// LOAD issuers are queued in an ordered tag FIFO so each response packet is routed back to its issuer.
module sam_cmd_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int TAG_DEPTH  = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [DATA_WIDTH-1:0]        s0_data,
  input  logic                         s0_valid,
  input  logic                         s0_last,
  output logic                         s0_ready,
  input  logic [DATA_WIDTH-1:0]        s1_data,
  input  logic                         s1_valid,
  input  logic                         s1_last,
  output logic                         s1_ready,
  output logic [DATA_WIDTH-1:0]        m_data,
  output logic                         m_valid,
  output logic                         m_last,
  input  logic                         m_ready,
  input  logic [DATA_WIDTH-1:0]        r_data,
  input  logic                         r_valid,
  input  logic                         r_last,
  output logic                         r_ready,
  output logic [DATA_WIDTH-1:0]        s0_rsp_data,
  output logic                         s0_rsp_valid,
  output logic                         s0_rsp_last,
  input  logic                         s0_rsp_ready,
  output logic [DATA_WIDTH-1:0]        s1_rsp_data,
  output logic                         s1_rsp_valid,
  output logic                         s1_rsp_last,
  input  logic                         s1_rsp_ready,
  output logic [$clog2(TAG_DEPTH):0]   outstanding,
  output logic                         err_unexpected
);
  localparam int PW = $clog2(TAG_DEPTH);

  typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_t;

  state_t               state_q, state_d;
  logic                 rr_q, rr_d;        // requester that held the last grant
  logic                 first_q, first_d;  // next transferred beat opens a packet
  logic [TAG_DEPTH-1:0] tag_q;
  logic [PW-1:0]        wr_q, rd_q;
  logic [PW:0]          cnt_q;
  logic                 err_q;

  logic                  gsel, sv, sl, is_load, stall, rdy;
  logic [DATA_WIDTH-1:0] sd;
  logic                  push, push_tag, pop, empty, full, head;

  assign empty = (cnt_q == '0);
  assign full  = (cnt_q == (PW+1)'(TAG_DEPTH));
  assign head  = tag_q[rd_q];

  always_comb begin
    state_d  = state_q;
    rr_d     = rr_q;
    first_d  = first_q;
    push     = 1'b0;
    push_tag = 1'b0;
    gsel     = 1'b0;
    sd       = '0;
    sv       = 1'b0;
    sl       = 1'b0;
    is_load  = 1'b0;
    stall    = 1'b0;
    rdy      = 1'b0;
    s0_ready = 1'b0;
    s1_ready = 1'b0;
    m_valid  = 1'b0;
    m_data   = '0;
    m_last   = 1'b0;
    case (state_q)
      IDLE: begin
        first_d = 1'b1;
        // On a tie, grant whoever did not hold the previous grant.
        if (s0_valid && s1_valid) state_d = rr_q ? GNT0 : GNT1;
        else if (s0_valid)        state_d = GNT0;
        else if (s1_valid)        state_d = GNT1;
      end
      GNT0, GNT1: begin
        gsel    = (state_q == GNT1);
        sd      = gsel ? s1_data  : s0_data;
        sv      = gsel ? s1_valid : s0_valid;
        sl      = gsel ? s1_last  : s0_last;
        is_load = first_q && (sd[DATA_WIDTH-1:DATA_WIDTH-2] == 2'b01);
        stall   = is_load && full;
        m_data  = sd;
        m_last  = sl;
        m_valid = sv && !stall;
        rdy     = m_ready && !stall;
        if (gsel) s1_ready = rdy;
        else      s0_ready = rdy;
        if (m_valid && m_ready) begin
          first_d  = 1'b0;
          push     = is_load;
          push_tag = gsel;
          if (sl) begin
            rr_d    = gsel;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    s0_rsp_data  = r_data;
    s1_rsp_data  = r_data;
    s0_rsp_last  = r_last;
    s1_rsp_last  = r_last;
    s0_rsp_valid = 1'b0;
    s1_rsp_valid = 1'b0;
    // With nothing outstanding the beat is swallowed so the SAM cannot wedge.
    if (empty) begin
      r_ready = r_valid;
    end else if (head) begin
      s1_rsp_valid = r_valid;
      r_ready      = s1_rsp_ready;
    end else begin
      s0_rsp_valid = r_valid;
      r_ready      = s0_rsp_ready;
    end
  end

  assign pop = !empty && r_valid && r_ready && r_last;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      rr_q    <= 1'b1;
      first_q <= 1'b1;
      tag_q   <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      first_q <= first_d;
      if (push) begin
        tag_q[wr_q] <= push_tag;
        wr_q        <= wr_q + 1'b1;
      end
      if (pop) rd_q <= rd_q + 1'b1;
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
      if (empty && r_valid) err_q <= 1'b1;
    end
  end

  assign outstanding    = cnt_q;
  assign err_unexpected = err_q;
endmodule

// File: tb/tb_sam_cmd_arbiter.sv
// Random traffic on both requesters and the response port, checked every cycle
// against a transaction-level model (owner id, tag queue, sticky error flag).
module tb_sam_cmd_arbiter;
  localparam int DW = 32;
  localparam int TD = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] s0_data, s1_data, m_data, r_data, s0_rsp_data, s1_rsp_data;
  logic          s0_valid, s0_last, s0_ready, s1_valid, s1_last, s1_ready;
  logic          m_valid, m_last, m_ready, r_valid, r_last, r_ready;
  logic          s0_rsp_valid, s0_rsp_last, s0_rsp_ready;
  logic          s1_rsp_valid, s1_rsp_last, s1_rsp_ready;
  logic [$clog2(TD):0] outstanding;
  logic          err_unexpected;

  always #5 clk = ~clk;

  sam_cmd_arbiter #(.DATA_WIDTH(DW), .TAG_DEPTH(TD)) dut (
    .clk(clk), .rst(rst),
    .s0_data(s0_data), .s0_valid(s0_valid), .s0_last(s0_last), .s0_ready(s0_ready),
    .s1_data(s1_data), .s1_valid(s1_valid), .s1_last(s1_last), .s1_ready(s1_ready),
    .m_data(m_data), .m_valid(m_valid), .m_last(m_last), .m_ready(m_ready),
    .r_data(r_data), .r_valid(r_valid), .r_last(r_last), .r_ready(r_ready),
    .s0_rsp_data(s0_rsp_data), .s0_rsp_valid(s0_rsp_valid), .s0_rsp_last(s0_rsp_last),
    .s0_rsp_ready(s0_rsp_ready),
    .s1_rsp_data(s1_rsp_data), .s1_rsp_valid(s1_rsp_valid), .s1_rsp_last(s1_rsp_last),
    .s1_rsp_ready(s1_rsp_ready),
    .outstanding(outstanding), .err_unexpected(err_unexpected)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // reference model: -1 = nobody granted, else granted requester
  int   owner;
  bit   first;
  int   last_gnt;
  bit   tags[$];
  bit   err;

  // requester packet generators
  int       len[2];
  int       beat[2];
  bit [1:0] op[2];

  task automatic new_pkt(input int x);
    int r;
    len[x]  = $urandom_range(1, 4);
    beat[x] = 0;
    r = $urandom_range(0, 9);
    op[x] = (r < 5) ? 2'b01 : (r < 8) ? 2'b00 : (r == 8) ? 2'b10 : 2'b11;
  endtask

  task automatic model_reset();
    owner = -1; first = 1'b1; last_gnt = 1; err = 1'b0;
    tags.delete();
  endtask

  task automatic check_and_step();
    logic [DW-1:0] d[2];
    bit v[2], l[2], rr[2];
    bit ld, stall, em_valid, er_ready, xfer, popf;
    bit es_ready[2], ersp_v[2];
    d[0] = s0_data; d[1] = s1_data;
    v[0] = s0_valid; v[1] = s1_valid;
    l[0] = s0_last;  l[1] = s1_last;
    rr[0] = s0_rsp_ready; rr[1] = s1_rsp_ready;
    ld = 0; stall = 0; em_valid = 0;
    es_ready[0] = 0; es_ready[1] = 0; ersp_v[0] = 0; ersp_v[1] = 0;
    if (owner >= 0) begin
      ld = first && (d[owner][DW-1:DW-2] == 2'b01);
      stall = ld && (tags.size() == TD);
      em_valid = v[owner] && !stall;
      es_ready[owner] = m_ready && !stall;
    end
    if (tags.size() == 0) er_ready = r_valid;
    else begin
      ersp_v[tags[0]] = r_valid;
      er_ready = rr[tags[0]];
    end
    chk("m_valid", m_valid, em_valid);
    chk("s0_ready", s0_ready, es_ready[0]);
    chk("s1_ready", s1_ready, es_ready[1]);
    if (em_valid) begin
      chk("m_data", m_data, d[owner]);
      chk("m_last", m_last, l[owner]);
    end
    chk("r_ready", r_ready, er_ready);
    chk("s0_rsp_valid", s0_rsp_valid, ersp_v[0]);
    chk("s1_rsp_valid", s1_rsp_valid, ersp_v[1]);
    if (ersp_v[0]) begin
      chk("s0_rsp_data", s0_rsp_data, r_data);
      chk("s0_rsp_last", s0_rsp_last, r_last);
    end
    if (ersp_v[1]) begin
      chk("s1_rsp_data", s1_rsp_data, r_data);
      chk("s1_rsp_last", s1_rsp_last, r_last);
    end
    chk("outstanding", outstanding, tags.size());
    chk("err_unexpected", err_unexpected, err);

    for (int x = 0; x < 2; x++)
      if (v[x] && es_ready[x]) begin
        beat[x]++;
        if (beat[x] == len[x]) new_pkt(x);
      end

    xfer = em_valid && m_ready;
    popf = (tags.size() > 0) && r_valid && er_ready && r_last;
    if (rst) begin
      model_reset();
      new_pkt(0);
      new_pkt(1);
    end else begin
      if (tags.size() == 0 && r_valid) err = 1'b1;
      if (popf) void'(tags.pop_front());
      if (owner < 0) begin
        first = 1'b1;
        if (v[0] && v[1]) owner = (last_gnt == 1) ? 0 : 1;
        else if (v[0])    owner = 0;
        else if (v[1])    owner = 1;
      end else if (xfer) begin
        if (ld) tags.push_back(owner == 1);
        first = 1'b0;
        if (l[owner]) begin
          last_gnt = owner;
          owner = -1;
        end
      end
    end
  endtask

  function automatic logic [DW-1:0] beat_data(input int x);
    logic [DW-1:0] w;
    w = $urandom;
    if (beat[x] == 0) w[DW-1:DW-2] = op[x];
    return w;
  endfunction

  task automatic drive(input int p_v, input int p_resp, input int p_rst, input bit unexp);
    rst          = ($urandom_range(0, 99) < p_rst);
    s0_valid     = ($urandom_range(0, 99) < p_v);
    s1_valid     = ($urandom_range(0, 99) < p_v);
    s0_data      = beat_data(0);
    s1_data      = beat_data(1);
    s0_last      = (beat[0] == len[0] - 1);
    s1_last      = (beat[1] == len[1] - 1);
    m_ready      = ($urandom_range(0, 99) < 75);
    s0_rsp_ready = ($urandom_range(0, 99) < 70);
    s1_rsp_ready = ($urandom_range(0, 99) < 70);
    r_valid      = (tags.size() > 0 || unexp) && ($urandom_range(0, 99) < p_resp);
    r_last       = $urandom_range(0, 1);
    r_data       = $urandom;
  endtask

  task automatic run(input int n, input int p_v, input int p_resp, input int p_rst,
                     input bit unexp);
    repeat (n) begin
      @(negedge clk);
      check_and_step();
      @(posedge clk);
      #1;
      drive(p_v, p_resp, p_rst, unexp);
    end
  endtask

  initial begin
    model_reset();
    new_pkt(0);
    new_pkt(1);
    rst = 1'b1;
    {s0_valid, s1_valid, s0_last, s1_last, m_ready, r_valid, r_last} = '0;
    {s0_rsp_ready, s1_rsp_ready} = '0;
    s0_data = '0; s1_data = '0; r_data = '0;
    @(posedge clk);
    #1;
    run(3,    0,   0, 100, 1'b0);  // held in reset
    run(200,  70,  0,   0, 1'b0);  // no responses: tag FIFO fills, LOADs stall
    run(1500, 70, 60,   0, 1'b0);  // mixed traffic with response backpressure
    run(1000, 80, 50,   3, 1'b0);  // random resets, including mid-packet
    run(300,  60, 40,   0, 1'b1);  // responses with nothing outstanding
    run(1,     0,  0, 100, 1'b0);  // reset clears sticky error
    run(10,    0,  0,   0, 1'b0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
